// File: rtl/gpu_net_pkg.sv
// Flit layout constants shared by the GPU network transmit and receive paths.
// The dest field sits in the top bits so the receive side can check dest == GPU_ID with a fixed slice.
package gpu_net_pkg;

   localparam int FLIT_W   = 16;
   localparam int DEST_W   = 6;
   localparam int PAY_W    = 10;
   localparam int DEST_MSB = 15;
   localparam int DEST_LSB = 10;
   localparam int PAY_MSB  = 9;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   function automatic logic [FLIT_W-1:0] make_flit(input logic [DEST_W-1:0] dest,
                                                   input logic [PAY_W-1:0]  payload);
      logic [FLIT_W-1:0] flit;
      flit                    = {FLIT_W{1'b0}};
      flit[DEST_MSB:DEST_LSB] = dest;
      flit[PAY_MSB:0]         = payload;
      return flit;
   endfunction

endpackage

// File: rtl/net_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
// ptr is expected to stay below N; the parent guarantees this.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any_valid
);

   // Scan offsets 0..N-1 from ptr; the lowest offset with a request wins.
   always_comb begin
      int pos;
      grant     = {N{1'b0}};
      idx       = {IDX_W{1'b0}};
      any_valid = 1'b0;
      pos       = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(ptr) + k) % N;
         if (req[pos] && !any_valid) begin
            any_valid = 1'b1;
            idx       = IDX_W'(pos);
         end else begin
            any_valid = any_valid;
         end
      end
      if (any_valid) begin
         grant[idx] = 1'b1;
      end else begin
         grant = {N{1'b0}};
      end
   end

endmodule

// File: rtl/net_tx_arbiter.sv
// Round-robin arbiter sharing one 16-bit NI transmit port between NUM_REQ requesters.
// Single-entry registered output stage; self-addressed flits are consumed and flagged on drop_pulse.
module net_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int GPU_ID  = 7,
   parameter int DEST_W  = 6,
   parameter int PAY_W   = 10,
   parameter int CNT_W   = 16
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic                         arb_en,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DEST_W-1:0]    req_dest,
   input  logic [NUM_REQ*PAY_W-1:0]     req_payload,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [15:0]                  net_data_out,
   output logic                         net_valid_out,
   input  logic                         net_ready_in,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         drop_pulse,
   output logic [CNT_W-1:0]             flit_count
);

   import gpu_net_pkg::*;

   localparam int                IDX_W    = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [DEST_W-1:0] SELF_ID  = DEST_W'(GPU_ID);

   out_state_t         state;
   out_state_t         state_nxt;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   rr_ptr_nxt;
   logic [NUM_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]   win_idx;
   logic               any_valid;
   logic               load_ok;
   logic               take;
   logic               self_drop;
   logic               load;
   logic               handshake;
   logic [DEST_W-1:0]  win_dest;
   logic [PAY_W-1:0]   win_payload;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (pick_grant),
      .idx       (win_idx),
      .any_valid (any_valid)
   );

   assign net_valid_out = (state == OUT_FULL);
   assign load_ok       = arb_en && (!net_valid_out || net_ready_in);
   assign handshake     = net_valid_out && net_ready_in;
   assign win_dest      = req_dest[win_idx*DEST_W +: DEST_W];
   assign win_payload   = req_payload[win_idx*PAY_W +: PAY_W];
   assign take          = load_ok && any_valid && !ARESET;
   assign self_drop     = take && (win_dest == SELF_ID);
   assign load          = take && !self_drop;
   assign req_ready     = take ? pick_grant : {NUM_REQ{1'b0}};
   assign rr_ptr_nxt    = (win_idx == LAST_IDX) ? {IDX_W{1'b0}} : win_idx + IDX_W'(1);

   // Output-stage occupancy: a load always refills, otherwise a handshake empties it.
   always_comb begin
      state_nxt = state;
      case (state)
         OUT_EMPTY: begin
            if (load) begin
               state_nxt = OUT_FULL;
            end else begin
               state_nxt = OUT_EMPTY;
            end
         end
         OUT_FULL: begin
            if (load) begin
               state_nxt = OUT_FULL;
            end else if (net_ready_in) begin
               state_nxt = OUT_EMPTY;
            end else begin
               state_nxt = OUT_FULL;
            end
         end
         default: state_nxt = OUT_EMPTY;
      endcase
   end

   // State register.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state <= OUT_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Output data, grant index, round-robin pointer, drop flag and sent-flit counter.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         net_data_out <= 16'h0000;
         grant_id     <= {IDX_W{1'b0}};
         rr_ptr       <= {IDX_W{1'b0}};
         drop_pulse   <= 1'b0;
         flit_count   <= {CNT_W{1'b0}};
      end else begin
         if (load) begin
            net_data_out <= make_flit(win_dest, win_payload);
            grant_id     <= win_idx;
         end
         if (take) begin
            rr_ptr <= rr_ptr_nxt;
         end
         drop_pulse <= self_drop;
         if (handshake) begin
            flit_count <= flit_count + CNT_W'(1);
         end
      end
   end

endmodule
